// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
//   Shares the asynchronous 512x8 data RAM (ram_512x8) between the pipeline
//   MEM stage (port P) and the loader/debug port (port L). A winner is picked
//   in IDLE, its request fields are latched, and the RAM pins are driven from
//   the latched copy for ACCESS_CYCLES cycles. Completion is a one-cycle
//   Ack. A misaligned request is either a one-cycle Fault or is aligned down,
//   depending on configuration.
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN  defined   : misaligned half/word requests fault.
//                        undefined : no FAULT state, PFault/LFault tied low,
//                                    misaligned addresses are aligned down.
//
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-low reset
//   PReq/LReq ...         per-requester request, ReadWrite (1=load), Size,
//                         SignExtend, Address (byte), DataIn (store data)
//   PAck/LAck             one-cycle completion pulse
//   PFault/LFault         one-cycle misalignment pulse
//   RdData                registered load data, held until the next load
//   Busy                  high whenever the FSM is not IDLE
//   Mem*                  RAM Enable/ReadWrite/Size/SignExtend/Address/DataIn
//   MemDataOut            RAM read data
module dmem_access_arbiter #(
  parameter int ACCESS_CYCLES = 2,  // 1..7
  parameter int STARVE_LIMIT  = 4   // 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PReq,
  input  logic        PReadWrite,
  input  logic [1:0]  PSize,
  input  logic        PSignExtend,
  input  logic [8:0]  PAddress,
  input  logic [31:0] PDataIn,
  input  logic        LReq,
  input  logic        LReadWrite,
  input  logic [1:0]  LSize,
  input  logic        LSignExtend,
  input  logic [8:0]  LAddress,
  input  logic [31:0] LDataIn,
  output logic        PAck,
  output logic        LAck,
  output logic        PFault,
  output logic        LFault,
  output logic [31:0] RdData,
  output logic        Busy,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [1:0]  MemSize,
  output logic        MemSignExtend,
  output logic [8:0]  MemAddress,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut
);

`ifdef DMEM_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  localparam logic [2:0] CNT_LAST   = 3'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [2:0]  cyc_cnt;
  logic [3:0]  starve_cnt;
  logic        win_l;
  logic        lat_rw;
  logic [1:0]  lat_size;
  logic        lat_sext;
  logic [8:0]  lat_addr;
  logic [31:0] lat_data;
  logic [31:0] rd_data_q;

  // Arbitration: P has priority until L has watched STARVE_LIMIT P grants.
  logic        any_req, grant_l;
  logic        sel_rw, sel_sext;
  logic [1:0]  sel_size_raw, sel_size;
  logic [8:0]  sel_addr, sel_addr_al;
  logic [31:0] sel_data;

  assign any_req      = PReq | LReq;
  assign grant_l      = LReq & (~PReq | (starve_cnt == STARVE_MAX));
  assign sel_rw       = grant_l ? LReadWrite  : PReadWrite;
  assign sel_size_raw = grant_l ? LSize       : PSize;
  assign sel_sext     = grant_l ? LSignExtend : PSignExtend;
  assign sel_addr     = grant_l ? LAddress    : PAddress;
  assign sel_data     = grant_l ? LDataIn     : PDataIn;
  // Reserved size 11 is presented to the RAM as a word access.
  assign sel_size     = (sel_size_raw == 2'b11) ? 2'b10 : sel_size_raw;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned  = ((sel_size == 2'b01) && sel_addr[0]) ||
                       ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
  // Faulting requests never reach the RAM, so the raw address is latched.
  assign sel_addr_al = sel_addr;
`else
  always_comb begin
    case (sel_size)
      2'b01:   sel_addr_al = {sel_addr[8:1], 1'b0};
      2'b10:   sel_addr_al = {sel_addr[8:2], 2'b00};
      default: sel_addr_al = sel_addr;
    endcase
  end
`endif

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
`ifdef DMEM_ALIGN_CHECK_EN
          state_nxt = misaligned ? FAULT : ACCESS;
`else
          state_nxt = ACCESS;
`endif
        end
      end
      ACCESS:  if (cyc_cnt == CNT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: the latched datapath registers are reset too, because they
      // drive the Mem* pins directly and those must read 0 after reset.
      state      <= IDLE;
      cyc_cnt    <= '0;
      starve_cnt <= '0;
      win_l      <= 1'b0;
      lat_rw     <= 1'b0;
      lat_size   <= '0;
      lat_sext   <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      rd_data_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!LReq || grant_l)
            starve_cnt <= '0;
          else if (starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 4'd1;  // P granted over a pending L
          if (any_req) begin
            win_l    <= grant_l;
            lat_rw   <= sel_rw;
            lat_size <= sel_size;
            lat_sext <= sel_sext;
            lat_addr <= sel_addr_al;
            lat_data <= sel_data;
            cyc_cnt  <= '0;
          end
        end
        ACCESS: begin
          cyc_cnt <= cyc_cnt + 3'd1;
          if ((cyc_cnt == CNT_LAST) && lat_rw)
            rd_data_q <= MemDataOut;
        end
        default: ;
      endcase
    end
  end

  // RAM pins hold the last latched request while idle; only Enable drops.
  assign MemEnable     = (state == ACCESS);
  assign MemReadWrite  = lat_rw;
  assign MemSize       = lat_size;
  assign MemSignExtend = lat_sext;
  assign MemAddress    = lat_addr;
  assign MemDataIn     = lat_data;

  assign RdData = rd_data_q;
  assign Busy   = (state != IDLE);
  assign PAck   = (state == RESP) & ~win_l;
  assign LAck   = (state == RESP) &  win_l;
`ifdef DMEM_ALIGN_CHECK_EN
  assign PFault = (state == FAULT) & ~win_l;
  assign LFault = (state == FAULT) &  win_l;
`else
  assign PFault = 1'b0;
  assign LFault = 1'b0;
`endif

endmodule
